// File: rtl/spm_pkg.sv
// Shared encodings for the SPM CPU: opcodes, bus mux selects and the control FSM states.
package spm_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL_R0 = 3'd0;
  localparam logic [2:0] SEL_R1 = 3'd1;
  localparam logic [2:0] SEL_R2 = 3'd2;
  localparam logic [2:0] SEL_R3 = 3'd3;
  localparam logic [2:0] SEL_PC = 3'd4;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_BUS1 = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

endpackage

// File: rtl/spm_control_unit.sv
// Instruction-sequencing FSM for the SPM CPU: fetch, decode and execute of the 9-opcode set.
module spm_control_unit
  import spm_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IR_OUT,
  input  logic       Z_OUT,
  output logic       load_R0,
  output logic       load_R1,
  output logic       load_R2,
  output logic       load_R3,
  output logic       load_PC,
  output logic       inc_PC,
  output logic       load_IR,
  output logic       load_Y,
  output logic       load_Z,
  output logic       load_addr,
  output logic [2:0] sel_mux1,
  output logic [1:0] sel_mux2,
  output logic [3:0] alu_op,
  output logic       mem_write,
  output logic       halted,
  output logic [3:0] state_dbg_o
);

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic [1:0] src, dest;
  logic [3:0] ld_r;

  assign opcode      = IR_OUT[7:4];
  assign src         = IR_OUT[3:2];
  assign dest        = IR_OUT[1:0];
  assign state_dbg_o = state_q;
  assign load_R0     = ld_r[0];
  assign load_R1     = ld_r[1];
  assign load_R2     = ld_r[2];
  assign load_R3     = ld_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: state_d = S_FET2;
      S_FET2: state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP:                 state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_d = S_EX1;
          OP_NOT:                 state_d = S_FET1;
          OP_RD:                  state_d = S_RD1;
          OP_WR:                  state_d = S_WR1;
          OP_BR:                  state_d = S_BR1;
          OP_BRZ:                 state_d = Z_OUT ? S_BR1 : S_FET1;
          default:                state_d = HALT_ON_ILLEGAL ? S_HALT : S_FET1;
        endcase
      end
      S_EX1:   state_d = S_FET1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_FET1;
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_FET1;
      S_BR1:   state_d = S_BR2;
      S_BR2:   state_d = S_FET1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are Moore except in S_DEC, where they depend on the opcode and Z_OUT.
  always_comb begin
    ld_r      = 4'b0000;
    load_PC   = 1'b0;
    inc_PC    = 1'b0;
    load_IR   = 1'b0;
    load_Y    = 1'b0;
    load_Z    = 1'b0;
    load_addr = 1'b0;
    sel_mux1  = SEL_R0;
    sel_mux2  = SEL_ALU;
    alu_op    = OP_NOP;
    mem_write = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FET1: begin
        sel_mux1 = SEL_PC; sel_mux2 = SEL_BUS1; load_addr = 1'b1;
      end
      S_FET2: begin
        sel_mux2 = SEL_MEM; load_IR = 1'b1; inc_PC = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            sel_mux1 = {1'b0, src}; sel_mux2 = SEL_BUS1; load_Y = 1'b1;
          end
          OP_NOT: begin
            sel_mux1 = {1'b0, src}; sel_mux2 = SEL_ALU; alu_op = OP_NOT;
            load_Z = 1'b1; ld_r = 4'b0001 << dest;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_mux1 = SEL_PC; sel_mux2 = SEL_BUS1; load_addr = 1'b1;
          end
          OP_BRZ: begin
            if (Z_OUT) begin
              sel_mux1 = SEL_PC; sel_mux2 = SEL_BUS1; load_addr = 1'b1;
            end else begin
              inc_PC = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        sel_mux1 = {1'b0, dest}; sel_mux2 = SEL_ALU; alu_op = opcode;
        load_Z = 1'b1; ld_r = 4'b0001 << dest;
      end
      S_RD1, S_WR1: begin
        sel_mux2 = SEL_MEM; load_addr = 1'b1; inc_PC = 1'b1;
      end
      S_RD2: begin
        sel_mux2 = SEL_MEM; ld_r = 4'b0001 << dest;
      end
      S_WR2: begin
        sel_mux1 = {1'b0, src}; mem_write = 1'b1;
      end
      S_BR1: begin
        sel_mux2 = SEL_MEM; load_addr = 1'b1;
      end
      S_BR2: begin
        sel_mux2 = SEL_MEM; load_PC = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spm_control_unit.sv
// Bench for spm_control_unit: each instruction expands into an expected per-cycle control sequence.
module tb_spm_control_unit;
  import spm_pkg::*;

  typedef struct packed {
    logic [3:0] ld_r;
    logic       ld_pc, inc_pc, ld_ir, ld_y, ld_z, ld_addr;
    logic [2:0] m1;
    logic [1:0] m2;
    logic [3:0] alu;
    logic       mw, halt;
  } ov_t;

  typedef struct {
    logic [7:0] ir;
    logic       z;
    ov_t        dec_exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] IR_OUT = 8'h00;
  logic       Z_OUT = 1'b0;
  logic       load_R0, load_R1, load_R2, load_R3, load_PC, inc_PC, load_IR;
  logic       load_Y, load_Z, load_addr, mem_write, halted;
  logic [2:0] sel_mux1;
  logic [1:0] sel_mux2;
  logic [3:0] alu_op, state_dbg;

  logic [20:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  spm_control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .IR_OUT(IR_OUT), .Z_OUT(Z_OUT),
    .load_R0(load_R0), .load_R1(load_R1), .load_R2(load_R2), .load_R3(load_R3),
    .load_PC(load_PC), .inc_PC(inc_PC), .load_IR(load_IR), .load_Y(load_Y),
    .load_Z(load_Z), .load_addr(load_addr), .sel_mux1(sel_mux1), .sel_mux2(sel_mux2),
    .alu_op(alu_op), .mem_write(mem_write), .halted(halted), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic ov_t mkv(input logic [3:0] ld_r, input logic ld_pc, inc_pc, ld_ir,
                              ld_y, ld_z, ld_addr, input logic [2:0] m1,
                              input logic [1:0] m2, input logic [3:0] alu,
                              input logic mw, halt);
    ov_t v;
    v = '{ld_r, ld_pc, inc_pc, ld_ir, ld_y, ld_z, ld_addr, m1, m2, alu, mw, halt};
    return v;
  endfunction

  function automatic ov_t cur();
    return mkv({load_R3, load_R2, load_R1, load_R0}, load_PC, inc_PC, load_IR, load_Y,
               load_Z, load_addr, sel_mux1, sel_mux2, alu_op, mem_write, halted);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    ov_t g;
    g = cur();
    check({tag, " pc_excl"}, 32'(g.ld_pc & g.inc_pc), 32'd0);
    check({tag, " r_onehot"}, 32'($countones(g.ld_r) <= 1), 32'd1);
    check({tag, " mw_excl"}, 32'(g.mw & (|g.ld_r)), 32'd0);
  endtask

  // Microprogram view of one instruction: fetch steps followed by its execute steps.
  task automatic model_instr(input logic [7:0] ir, input logic z);
    logic [3:0] op;
    logic [2:0] s, d;
    logic [3:0] oh;
    ov_t fa;
    op = ir[7:4]; s = {1'b0, ir[3:2]}; d = {1'b0, ir[1:0]};
    oh = 4'b0001 << ir[1:0];
    fa = mkv(4'h0, 0, 0, 0, 0, 0, 1, 3'd4, 2'd1, 4'd0, 0, 0);
    exp_q.push_back(fa);
    exp_q.push_back(mkv(4'h0, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 4'd0, 0, 0));
    if (op >= 4'd1 && op <= 4'd3) begin
      exp_q.push_back(mkv(4'h0, 0, 0, 0, 1, 0, 0, s, 2'd1, 4'd0, 0, 0));
      exp_q.push_back(mkv(oh, 0, 0, 0, 0, 1, 0, d, 2'd0, op, 0, 0));
    end else if (op == 4'd4) begin
      exp_q.push_back(mkv(oh, 0, 0, 0, 0, 1, 0, s, 2'd0, 4'd4, 0, 0));
    end else if (op == 4'd5) begin
      exp_q.push_back(fa);
      exp_q.push_back(mkv(4'h0, 0, 1, 0, 0, 0, 1, 3'd0, 2'd2, 4'd0, 0, 0));
      exp_q.push_back(mkv(oh, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 4'd0, 0, 0));
    end else if (op == 4'd6) begin
      exp_q.push_back(fa);
      exp_q.push_back(mkv(4'h0, 0, 1, 0, 0, 0, 1, 3'd0, 2'd2, 4'd0, 0, 0));
      exp_q.push_back(mkv(4'h0, 0, 0, 0, 0, 0, 0, s, 2'd0, 4'd0, 1, 0));
    end else if (op == 4'd7 || (op == 4'd8 && z)) begin
      exp_q.push_back(fa);
      exp_q.push_back(mkv(4'h0, 0, 0, 0, 0, 0, 1, 3'd0, 2'd2, 4'd0, 0, 0));
      exp_q.push_back(mkv(4'h0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 4'd0, 0, 0));
    end else if (op == 4'd8) begin
      exp_q.push_back(mkv(4'h0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 4'd0, 0, 0));
    end else begin
      exp_q.push_back(ov_t'(0));
    end
  endtask

  // Runs one instruction from S_FET1; abort_at >= 0 pulses reset right after that cycle.
  task automatic run_instr(input string tag, input logic [7:0] ir, input logic z,
                           input logic dec_valid, input ov_t dec_exp, input int abort_at);
    int n;
    exp_q.delete();
    model_instr(ir, z);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin IR_OUT = ir; Z_OUT = z; end
      #1;
      if (i == 0) check($sformatf("%s start_fet1", tag), 32'(state_dbg == S_FET1), 32'd1);
      else        check($sformatf("%s not_fet1[%0d]", tag, i), 32'(state_dbg != S_FET1), 32'd1);
      check($sformatf("%s cyc%0d", tag, i), 32'(cur()), 32'(exp_q.pop_front()));
      if (i == 2 && dec_valid) check($sformatf("%s dec_tbl", tag), 32'(cur()), 32'(dec_exp));
      check_inv(tag);
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check($sformatf("%s async_rst", tag), 32'(cur()), 32'd0);
        @(negedge clk);
        check($sformatf("%s rst_held", tag), 32'(cur()), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        return;
      end
    end
  endtask

  vec_t tbl[$];
  ov_t  fa_v, zero_v;

  initial begin
    fa_v   = mkv(4'h0, 0, 0, 0, 0, 0, 1, 3'd4, 2'd1, 4'd0, 0, 0);
    zero_v = ov_t'(0);
    tbl.push_back('{8'h16, 1'b0, mkv(4'h0, 0, 0, 0, 1, 0, 0, 3'd1, 2'd1, 4'd0, 0, 0)});
    tbl.push_back('{8'h15, 1'b1, mkv(4'h0, 0, 0, 0, 1, 0, 0, 3'd1, 2'd1, 4'd0, 0, 0)});
    tbl.push_back('{8'h27, 1'b0, mkv(4'h0, 0, 0, 0, 1, 0, 0, 3'd1, 2'd1, 4'd0, 0, 0)});
    tbl.push_back('{8'h3E, 1'b1, mkv(4'h0, 0, 0, 0, 1, 0, 0, 3'd3, 2'd1, 4'd0, 0, 0)});
    tbl.push_back('{8'h4B, 1'b0, mkv(4'h8, 0, 0, 0, 0, 1, 0, 3'd2, 2'd0, 4'd4, 0, 0)});
    tbl.push_back('{8'h5C, 1'b0, fa_v});
    tbl.push_back('{8'h64, 1'b1, fa_v});
    tbl.push_back('{8'h70, 1'b0, fa_v});
    tbl.push_back('{8'h80, 1'b0, mkv(4'h0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 4'd0, 0, 0)});
    tbl.push_back('{8'h80, 1'b1, fa_v});
    tbl.push_back('{8'h00, 1'b1, zero_v});

    #12;
    check("reset_outputs", 32'(cur()), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_outputs", 32'(cur()), 32'd0);
    check("idle_state", 32'(state_dbg), 32'(S_IDLE));

    foreach (tbl[k])
      run_instr($sformatf("tbl%0d_%h", k, tbl[k].ir), tbl[k].ir, tbl[k].z, 1'b1, tbl[k].dec_exp, -1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ir;
      ir = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
      run_instr($sformatf("rnd%0d_%h", k, ir), ir, 1'($urandom_range(0, 1)), 1'b0, zero_v, -1);
    end

    // Reset while the write strobe is up: abandoned instruction, resume at fetch.
    run_instr("wr_abort", 8'h6D, 1'b0, 1'b0, zero_v, 4);
    run_instr("after_abort", 8'h29, 1'b0, 1'b0, zero_v, -1);

    run_instr("illegal", 8'hF0, 1'b0, 1'b1, zero_v, -1);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("halt%0d", k), 32'(cur()), 32'(mkv(4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 4'd0, 0, 1)));
    end
    rst = 1'b0;
    #1;
    check("halt_rst", 32'(cur()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("halt_rst_idle", 32'(state_dbg), 32'(S_IDLE));
    run_instr("post_halt", 8'h5E, 1'b1, 1'b0, zero_v, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spm_control_unit.md
Name: spm_control_unit

Overview:
- Instruction-sequencing FSM that drives every control input of the SPM CPU datapath.
- Consumes the datapath's instruction register (IR_OUT) and zero flag (Z_OUT).
- Produces register-load strobes, PC load/increment, bus mux selects, ALU op select and the memory write strobe.
- Implements fetch, decode and execute for the 9-opcode SPM instruction set; halts on illegal opcodes.

Parameters:
HALT_ON_ILLEGAL, 1, 1: illegal opcode enters S_HALT; 0: illegal opcode is executed as NOP.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
IR_OUT  input  8  instruction: [7:4] opcode, [3:2] src reg, [1:0] dest reg
Z_OUT  input  1  registered zero flag from datapath
load_R0, load_R1, load_R2, load_R3  output  1 each  register load strobes
load_PC  output  1  PC parallel load
inc_PC  output  1  PC increment
load_IR, load_Y, load_Z, load_addr  output  1 each  load strobes
sel_mux1  output  3  bus_1 source: 0..3 = R0..R3, 4 = PC
sel_mux2  output  2  bus_2 source: 0 = ALU, 1 = bus_1, 2 = mem_word
alu_op  output  4  ALU op code, same encoding as the opcode
mem_write  output  1  memory write strobe; data on bus_1, address in ADDR
halted  output  1  high while in S_HALT

Behaviour:
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Codes 9..15 are illegal.
- State register: async clear on rst=0 to S_IDLE. Next state is taken at posedge clk.
- Outputs are combinational from state and IR_OUT/Z_OUT (Mealy in S_DEC only).
- Default value of every output in every state: 0, including during and immediately after reset.
- S_IDLE: no outputs asserted. Next: S_FET1.
- S_FET1: sel_mux1=4, sel_mux2=1, load_addr. Next: S_FET2.
- S_FET2: sel_mux2=2, load_IR, inc_PC. Next: S_DEC.
- S_DEC (IR now valid):
  - NOP: no outputs. Next: S_FET1.
  - ADD/SUB/AND: sel_mux1=src, sel_mux2=1, load_Y. Next: S_EX1.
  - NOT: sel_mux1=src, sel_mux2=0, alu_op=4, load_Z, load_R[dest]. Next: S_FET1.
  - RD/WR/BR: sel_mux1=4, sel_mux2=1, load_addr. Next: S_RD1 / S_WR1 / S_BR1 respectively.
  - BRZ, Z_OUT=1: same outputs as BR. Next: S_BR1.
  - BRZ, Z_OUT=0: inc_PC only, skipping the operand byte. Next: S_FET1.
  - Illegal: if HALT_ON_ILLEGAL, next S_HALT; otherwise behave as NOP.
- S_EX1: sel_mux1=dest, sel_mux2=0, alu_op=opcode, load_Z, load_R[dest]. Next: S_FET1.
- S_RD1: sel_mux2=2, load_addr, inc_PC. Next: S_RD2.
- S_RD2: sel_mux2=2, load_R[dest]. Next: S_FET1.
- S_WR1: sel_mux2=2, load_addr, inc_PC. Next: S_WR2.
- S_WR2: sel_mux1=src, mem_write. Next: S_FET1.
- S_BR1: sel_mux2=2, load_addr. Next: S_BR2.
- S_BR2: sel_mux2=2, load_PC. Next: S_FET1.
- S_HALT: halted=1, all other outputs 0. Remains in S_HALT until reset.
- Cycles per instruction, S_FET1 through the last execute state:
  - NOP, NOT, BRZ not taken: 3
  - ADD/SUB/AND: 4
  - RD, WR, BR, BRZ taken: 5
- Invariants:
  - load_PC and inc_PC are never both high.
  - At most one of load_R0..R3 is high in any cycle.
  - mem_write is never high together with any register load.
- Register equality: src==dest is legal (e.g. ADD R1,R1 doubles R1).
- Reset mid-instruction: all outputs drop to 0 asynchronously. The instruction is abandoned and the next instruction starts at S_FET1 one cycle after rst deasserts.

Decomposition:
- Shared package spm_pkg holds:
  - opcode localparams NOP..BRZ
  - sel_mux1 codes SEL_R0..SEL_R3 and SEL_PC
  - sel_mux2 codes SEL_ALU, SEL_BUS1, SEL_MEM
  - state encoding (4-bit, 12 states)
- No sub-module: a single FSM with a next-state always block and an output always block.
- Integration top spm_cpu instantiates this block with cpu_datapath and a memory model.

Test Plan:
- Reset, then release → S_IDLE for 1 cycle; first FET1 asserts sel_mux1=4, sel_mux2=1, load_addr; all other outputs 0.
- IR=8'h16 (ADD src=R1, dest=R2) → DEC: load_Y, sel_mux1=1; EX1: sel_mux1=2, sel_mux2=0, alu_op=1, load_R2, load_Z. Total 4 cycles.
- IR=8'h5C (RD dest=R0) → RD1 asserts load_addr and inc_PC; RD2 asserts load_R0 with sel_mux2=2. Total 5 cycles; inc_PC asserted twice per instruction.
- IR=8'h80 (BRZ) with Z_OUT=0 → DEC asserts inc_PC only, next is FET1 (3 cycles). With Z_OUT=1 → BR1 then BR2 with load_PC, sel_mux2=2 (5 cycles).
- IR=8'hF0 with HALT_ON_ILLEGAL=1 → halted=1 from the cycle after DEC and held for 20+ cycles. rst pulse → S_IDLE, halted=0.
- Assert rst during S_WR2 → mem_write falls in the same cycle without waiting for a clock edge; after release the FSM resumes at FET1.
